regfile_operand_fetch: RTL and testbench

// - General-purpose register file and operand-fetch stage directly upstream of the ALU interface.
// - Captures decoded source/destination fields, drives registered A_bus/B_bus and the ALU operand enables for EXECUTE1/EXECUTE2.
// - Writes alu_result and the condition codes back in WRITEBACK.
// - Provides an immediate-load port usable in FETCH.

---
 rtl/regfile_operand_fetch_if.sv | 66 ++++++
 rtl/regfile_operand_fetch.sv | 194 +++++++++++++++++++
 tb/tb_regfile_operand_fetch.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_operand_fetch_if.sv
// ---------------------------------------------------------------------------
// regfile_operand_fetch_if
// Purpose : bundles the sequencer state, decoded instruction fields, ALU
//           writeback inputs, immediate-load handshake and operand outputs of
//           the register-file / operand-fetch stage into one interface.
// Modports:
//   slave  - the register file (regfile_operand_fetch) side
//   master - the sequencer / decoder / ALU side that drives it
// Signals : cpu_state, dec_src_a, dec_src_b, dec_use_a, dec_use_b, dec_dst,
//           dec_wb_en, dec_flag_we, alu_result, cc_greater, cc_equal,
//           imm_we, imm_addr, imm_data (to slave);
//           A_bus, B_bus, alu_en_A_reg, alu_en_B_reg, flag_gt, flag_eq,
//           imm_ack (from slave).
// Handshake: imm_we is a request that the master holds steady (with
//           imm_addr/imm_data) until it sees imm_ack; imm_ack is a single
//           cycle pulse meaning the write has been committed, after which the
//           master drops or replaces the request.
// ---------------------------------------------------------------------------
`ifndef ALU_WIDTH
`define ALU_WIDTH 8
`endif
`ifndef CPU_STATES
`define CPU_STATES 5
`endif

interface regfile_operand_fetch_if #(
  parameter int DATA_WIDTH = `ALU_WIDTH,
  parameter int ADDR_W     = 3,
  parameter int STATE_W    = $clog2(`CPU_STATES)
);
  logic [STATE_W-1:0]    cpu_state;
  logic [ADDR_W-1:0]     dec_src_a;
  logic [ADDR_W-1:0]     dec_src_b;
  logic                  dec_use_a;
  logic                  dec_use_b;
  logic [ADDR_W-1:0]     dec_dst;
  logic                  dec_wb_en;
  logic                  dec_flag_we;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  cc_greater;
  logic                  cc_equal;
  logic                  imm_we;
  logic [ADDR_W-1:0]     imm_addr;
  logic [DATA_WIDTH-1:0] imm_data;
  logic [DATA_WIDTH-1:0] A_bus;
  logic [DATA_WIDTH-1:0] B_bus;
  logic                  alu_en_A_reg;
  logic                  alu_en_B_reg;
  logic                  flag_gt;
  logic                  flag_eq;
  logic                  imm_ack;

  modport slave (
    input  cpu_state, dec_src_a, dec_src_b, dec_use_a, dec_use_b, dec_dst,
           dec_wb_en, dec_flag_we, alu_result, cc_greater, cc_equal,
           imm_we, imm_addr, imm_data,
    output A_bus, B_bus, alu_en_A_reg, alu_en_B_reg, flag_gt, flag_eq, imm_ack
  );

  modport master (
    output cpu_state, dec_src_a, dec_src_b, dec_use_a, dec_use_b, dec_dst,
           dec_wb_en, dec_flag_we, alu_result, cc_greater, cc_equal,
           imm_we, imm_addr, imm_data,
    input  A_bus, B_bus, alu_en_A_reg, alu_en_B_reg, flag_gt, flag_eq, imm_ack
  );
endinterface

// File: rtl/regfile_operand_fetch.sv
// ---------------------------------------------------------------------------
// regfile_operand_fetch
// Purpose : general-purpose register file plus operand-fetch stage sitting in
//           front of the ALU. Operands are read on the DECODE edge into the
//           registered A_bus/B_bus, ALU load enables are held through
//           EXECUTE1/EXECUTE2, and the ALU result / condition codes are
//           written back on the WRITEBACK edge. An immediate-load port writes
//           the register file on a FETCH edge and acknowledges with imm_ack.
// Ports   :
//   sys_clk      - clock, rising edge
//   sys_reset_n  - asynchronous active-low reset
//   bus          - regfile_operand_fetch_if.slave (sequencer state, decode
//                  fields, ALU result/flags, immediate port, operand outputs)
// Parameters:
//   DATA_WIDTH   - register/bus width, equal to the ALU width
//   NUM_REGS     - register count, power of two and >= 2
//   ADDR_W       - derived register address width
// Build option:
//   ZERO_REG_EN  - when defined, r0 is hard-wired to zero: it reads as 0 and
//                  writes to it are discarded (an immediate write to r0 is
//                  still acknowledged). Undefined: r0 is an ordinary register.
// State encodings come from `FETCH/`DECODE/`EXECUTE1/`EXECUTE2/`WRITEBACK;
// any other cpu_state value is idle (no reads, no writes, outputs hold).
// ---------------------------------------------------------------------------
`ifndef ALU_WIDTH
`define ALU_WIDTH 8
`endif
`ifndef CPU_STATES
`define CPU_STATES 5
`endif
`ifndef FETCH
`define FETCH 0
`endif
`ifndef DECODE
`define DECODE 1
`endif
`ifndef EXECUTE1
`define EXECUTE1 2
`endif
`ifndef EXECUTE2
`define EXECUTE2 3
`endif
`ifndef WRITEBACK
`define WRITEBACK 4
`endif

module regfile_operand_fetch #(
  parameter int DATA_WIDTH = `ALU_WIDTH,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                   sys_clk,
  input  logic                   sys_reset_n,
  regfile_operand_fetch_if.slave bus
);

  localparam int STATE_W = $clog2(`CPU_STATES);

  localparam logic [STATE_W-1:0] ST_FETCH     = STATE_W'(`FETCH);
  localparam logic [STATE_W-1:0] ST_DECODE    = STATE_W'(`DECODE);
  localparam logic [STATE_W-1:0] ST_EXECUTE2  = STATE_W'(`EXECUTE2);
  localparam logic [STATE_W-1:0] ST_WRITEBACK = STATE_W'(`WRITEBACK);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];

  logic [ADDR_W-1:0]     dst_q;
  logic                  wb_en_q;
  logic                  flag_we_q;

  logic [DATA_WIDTH-1:0] a_bus_q;
  logic [DATA_WIDTH-1:0] b_bus_q;
  logic                  en_a_q;
  logic                  en_b_q;
  logic                  flag_gt_q;
  logic                  flag_eq_q;
  logic                  imm_ack_q;

  // -------------------------------------------------------------------------
  // Combinational read / write selection
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  imm_ack_d;

  always_comb begin
    rd_a = rf_q[bus.dec_src_a];
    rd_b = rf_q[bus.dec_src_b];
`ifdef ZERO_REG_EN
    if (bus.dec_src_a == '0) rd_a = '0;
    if (bus.dec_src_b == '0) rd_b = '0;
`endif
  end

  // Reads happen only at DECODE and writes only at FETCH/WRITEBACK, so the
  // two write sources never collide and no read/write bypass is needed.
  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    imm_ack_d = 1'b0;
    if (bus.cpu_state == ST_FETCH && bus.imm_we) begin
      wr_en     = 1'b1;
      wr_addr   = bus.imm_addr;
      wr_data   = bus.imm_data;
      imm_ack_d = 1'b1;
    end else if (bus.cpu_state == ST_WRITEBACK && wb_en_q) begin
      wr_en   = 1'b1;
      wr_addr = dst_q;
      wr_data = bus.alu_result;
    end
`ifdef ZERO_REG_EN
    // Writes to r0 are dropped; the immediate acknowledge above still fires.
    if (wr_addr == '0) wr_en = 1'b0;
`endif
  end

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Decode latch, operand buses, enables, flags, immediate acknowledge
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      dst_q     <= '0;
      wb_en_q   <= 1'b0;
      flag_we_q <= 1'b0;
      a_bus_q   <= '0;
      b_bus_q   <= '0;
      en_a_q    <= 1'b0;
      en_b_q    <= 1'b0;
      flag_gt_q <= 1'b0;
      flag_eq_q <= 1'b0;
      imm_ack_q <= 1'b0;
    end else begin
      // imm_ack is a pulse: it is only ever high for the cycle after a FETCH
      // commit, including when the following state is unknown/idle.
      imm_ack_q <= imm_ack_d;
      case (bus.cpu_state)
        ST_DECODE: begin
          dst_q     <= bus.dec_dst;
          wb_en_q   <= bus.dec_wb_en;
          flag_we_q <= bus.dec_flag_we;
          // An unused operand leaves its bus untouched so the ALU input
          // does not toggle needlessly.
          if (bus.dec_use_a) a_bus_q <= rd_a;
          if (bus.dec_use_b) b_bus_q <= rd_b;
          en_a_q    <= bus.dec_use_a;
          en_b_q    <= bus.dec_use_b;
        end
        ST_EXECUTE2: begin
          // Enables cover EXECUTE1 and EXECUTE2 and drop when leaving EXECUTE2.
          en_a_q <= 1'b0;
          en_b_q <= 1'b0;
        end
        ST_WRITEBACK: begin
          if (flag_we_q) begin
            flag_gt_q <= bus.cc_greater;
            flag_eq_q <= bus.cc_equal;
          end
        end
        default: begin
          // FETCH, EXECUTE1 and unknown encodings: hold everything.
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.A_bus        = a_bus_q;
  assign bus.B_bus        = b_bus_q;
  assign bus.alu_en_A_reg = en_a_q;
  assign bus.alu_en_B_reg = en_b_q;
  assign bus.flag_gt      = flag_gt_q;
  assign bus.flag_eq      = flag_eq_q;
  assign bus.imm_ack      = imm_ack_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_regfile_operand_fetch
// Directed bench for regfile_operand_fetch. A small register/flag model
// produces the expected operand values, which are queued when an instruction
// is decoded and compared when the operand buses are presented in EXECUTE1.
// ZERO_REG_EN, when defined for the build, is honoured by the model.
// ---------------------------------------------------------------------------
`ifndef ALU_WIDTH
`define ALU_WIDTH 8
`endif

module tb_regfile_operand_fetch;

  localparam int DW = `ALU_WIDTH;
  localparam int AW = 3;
  localparam int SW = 3;

  localparam logic [SW-1:0] S_F   = 3'd0;
  localparam logic [SW-1:0] S_D   = 3'd1;
  localparam logic [SW-1:0] S_E1  = 3'd2;
  localparam logic [SW-1:0] S_E2  = 3'd3;
  localparam logic [SW-1:0] S_WB  = 3'd4;
  localparam logic [SW-1:0] S_BAD = 3'd7;

  // ---------------- clock / reset ----------------
  logic sys_clk     = 1'b0;
  logic sys_reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  regfile_operand_fetch_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) ifc ();

  regfile_operand_fetch #(.DATA_WIDTH(DW), .NUM_REGS(8)) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .bus         (ifc)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl [8];
  logic          m_gt, m_eq;
  logic [DW-1:0] m_a_bus, m_b_bus;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
`ifdef ZERO_REG_EN
    if (a == '0) return '0;
`endif
    return mdl[a];
  endfunction

  task automatic m_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef ZERO_REG_EN
    if (a == '0) return;
`endif
    mdl[a] = d;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    m_gt = 1'b0; m_eq = 1'b0;
    m_a_bus = '0; m_b_bus = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at posedge+1; the next posedge applies them, outputs are
  // sampled at posedge+1 on return.
  task automatic tick(input logic [SW-1:0] st);
    ifc.cpu_state = st;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.cpu_state   = S_F;
    ifc.dec_src_a   = '0; ifc.dec_src_b = '0;
    ifc.dec_use_a   = 1'b0; ifc.dec_use_b = 1'b0;
    ifc.dec_dst     = '0; ifc.dec_wb_en = 1'b0; ifc.dec_flag_we = 1'b0;
    ifc.alu_result  = '0; ifc.cc_greater = 1'b0; ifc.cc_equal = 1'b0;
    ifc.imm_we      = 1'b0; ifc.imm_addr = '0; ifc.imm_data = '0;
  endtask

  task automatic imm_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ifc.imm_we = 1'b1; ifc.imm_addr = a; ifc.imm_data = d;
    tick(S_F);
    check("imm_ack_set", DW'(ifc.imm_ack), DW'(1));
    m_wr(a, d);
    ifc.imm_we = 1'b0;
    tick(S_F);
    check("imm_ack_pulse", DW'(ifc.imm_ack), DW'(0));
  endtask

  // One instruction DECODE..WRITEBACK. is_cmp: ALU drives compare codes,
  // otherwise it drives sum with deliberately non-matching condition codes.
  task automatic instr(input logic [AW-1:0] sa, input logic ua,
                       input logic [AW-1:0] sb, input logic ub,
                       input logic [AW-1:0] dst, input logic wb,
                       input logic fwe, input logic is_cmp, input string tag);
    logic [DW-1:0] res;
    if (ua) m_a_bus = m_rd(sa);
    if (ub) m_b_bus = m_rd(sb);
    exp_q.push_back(m_a_bus);
    exp_q.push_back(m_b_bus);
    ifc.dec_src_a = sa; ifc.dec_use_a = ua;
    ifc.dec_src_b = sb; ifc.dec_use_b = ub;
    ifc.dec_dst = dst; ifc.dec_wb_en = wb; ifc.dec_flag_we = fwe;
    tick(S_D);
    check({tag, "_A_bus"}, ifc.A_bus, exp_q.pop_front());
    check({tag, "_B_bus"}, ifc.B_bus, exp_q.pop_front());
    check({tag, "_enA_e1"}, DW'(ifc.alu_en_A_reg), DW'(ua));
    check({tag, "_enB_e1"}, DW'(ifc.alu_en_B_reg), DW'(ub));
    ifc.dec_use_a = 1'b0; ifc.dec_use_b = 1'b0;
    tick(S_E1);
    check({tag, "_A_hold_e2"}, ifc.A_bus, m_a_bus);
    check({tag, "_enA_e2"}, DW'(ifc.alu_en_A_reg), DW'(ua));
    check({tag, "_enB_e2"}, DW'(ifc.alu_en_B_reg), DW'(ub));
    tick(S_E2);
    check({tag, "_enA_off"}, DW'(ifc.alu_en_A_reg), DW'(0));
    check({tag, "_enB_off"}, DW'(ifc.alu_en_B_reg), DW'(0));
    res = m_a_bus + m_b_bus;
    ifc.alu_result = res;
    if (is_cmp) begin
      ifc.cc_greater = (m_a_bus > m_b_bus);
      ifc.cc_equal   = (m_a_bus == m_b_bus);
    end else begin
      ifc.cc_greater = ~m_gt;
      ifc.cc_equal   = ~m_eq;
    end
    if (wb) m_wr(dst, res);
    if (fwe) begin m_gt = ifc.cc_greater; m_eq = ifc.cc_equal; end
    tick(S_WB);
    check({tag, "_flag_gt"}, DW'(ifc.flag_gt), DW'(m_gt));
    check({tag, "_flag_eq"}, DW'(ifc.flag_eq), DW'(m_eq));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    clear_inputs();
    m_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_A_bus", ifc.A_bus, '0);
    check("rst_B_bus", ifc.B_bus, '0);
    check("rst_enA", DW'(ifc.alu_en_A_reg), DW'(0));
    check("rst_enB", DW'(ifc.alu_en_B_reg), DW'(0));
    check("rst_flag_gt", DW'(ifc.flag_gt), DW'(0));
    check("rst_flag_eq", DW'(ifc.flag_eq), DW'(0));
    check("rst_imm_ack", DW'(ifc.imm_ack), DW'(0));
    sys_reset_n = 1'b1;
    tick(S_F);

    // Immediate write in FETCH, then an ignored one in DECODE.
    imm_write(3'd1, 8'h12);
    ifc.imm_we = 1'b1; ifc.imm_addr = 3'd1; ifc.imm_data = 8'h77;
    tick(S_D);
    check("imm_in_decode_no_ack", DW'(ifc.imm_ack), DW'(0));
    ifc.imm_we = 1'b0;
    tick(S_F);
    check("imm_in_decode_no_ack2", DW'(ifc.imm_ack), DW'(0));

    // ADD r2 = r1 + r0.
    imm_write(3'd0, 8'h03);
    instr(3'd1, 1'b1, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, "add_r2");
    tick(S_F);

    // CMP r1,r2 (r1 unchanged by the DECODE-state request).
    instr(3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, "cmp_lt");
    tick(S_F);

    // CMP with equal operands, then ADD without flag update holds flags.
    imm_write(3'd1, m_rd(3'd2));
    instr(3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, "cmp_eq");
    tick(S_F);
    instr(3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, "add_hold");
    tick(S_F);
    instr(3'd2, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, "cmp_gt");
    tick(S_F);

    // Only A used: B bus holds its previous value.
    instr(3'd3, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "a_only");
    tick(S_F);

    // Back-to-back: WRITEBACK r4 straight into DECODE of r4 (both sources).
    instr(3'd1, 1'b1, 3'd0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, "wr_r4");
    instr(3'd4, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "rd_r4");
    tick(S_F);

    // r0 after an immediate write of FF.
    imm_write(3'd0, 8'hFF);
    instr(3'd0, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "rd_r0");
    tick(S_F);

    // Unknown state: no reads, no writes, no ack, outputs hold.
    ifc.dec_src_a = 3'd1; ifc.dec_use_a = 1'b1;
    ifc.dec_src_b = 3'd2; ifc.dec_use_b = 1'b1;
    ifc.imm_we = 1'b1; ifc.imm_addr = 3'd6;
    ifc.imm_data = DW'($urandom_range(1, 255));
    tick(S_BAD);
    check("bad_A_hold", ifc.A_bus, m_a_bus);
    check("bad_B_hold", ifc.B_bus, m_b_bus);
    check("bad_enA", DW'(ifc.alu_en_A_reg), DW'(0));
    check("bad_no_ack", DW'(ifc.imm_ack), DW'(0));
    ifc.imm_we = 1'b0;
    tick(S_F);
    instr(3'd6, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "rd_r6");
    tick(S_F);

    // Asynchronous reset in the middle of EXECUTE1.
    imm_write(3'd3, 8'h5A);
    ifc.dec_src_a = 3'd3; ifc.dec_use_a = 1'b1;
    ifc.dec_src_b = 3'd3; ifc.dec_use_b = 1'b1;
    ifc.dec_dst = 3'd3; ifc.dec_wb_en = 1'b1; ifc.dec_flag_we = 1'b1;
    tick(S_D);
    check("pre_rst_A_bus", ifc.A_bus, 8'h5A);
    ifc.cpu_state = S_E1;
    #2;
    sys_reset_n = 1'b0;
    #1;
    m_reset();
    check("arst_A_bus", ifc.A_bus, '0);
    check("arst_B_bus", ifc.B_bus, '0);
    check("arst_enA", DW'(ifc.alu_en_A_reg), DW'(0));
    check("arst_enB", DW'(ifc.alu_en_B_reg), DW'(0));
    check("arst_flags", DW'({ifc.flag_gt, ifc.flag_eq}), DW'(0));
    check("arst_imm_ack", DW'(ifc.imm_ack), DW'(0));
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    @(posedge sys_clk);
    #1;
    clear_inputs();
    tick(S_F);
    instr(3'd3, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "post_rst_r3");
    tick(S_F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
